// File: rtl/req_grant_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module  : req_grant_arbiter_n
// Brief   : N-channel request/grant arbiter, fixed-priority or round-robin,
//           registered one-hot grant held while the owner keeps requesting.
//           Optional macro HOLD_LIMIT_EN caps a grant at MAX_HOLD cycles.
// Revision: 1.0 - initial release
// ============================================================================
module req_grant_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mode,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  generate
    if (N < 2 || N > 32 || MAX_HOLD < 1) begin : g_param_check
      $error("req_grant_arbiter_n: illegal N or MAX_HOLD");
    end
  endgenerate

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [IDXW-1:0] r_last, w_last_nxt;
  logic [N-1:0]    w_cand;
  logic [N-1:0]    w_win_oh;
  logic [IDXW-1:0] w_win;
  logic            w_owner_req;
  int              w_key, w_best_key;

`ifdef HOLD_LIMIT_EN
  localparam int CNTW = $clog2(MAX_HOLD + 1);
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic [N-1:0]    w_others;

  // A timed-out owner steps aside only if someone else is waiting.
  always_comb begin
    w_others = req & ~({{(N-1){1'b0}}, 1'b1} << r_last);
    w_cand   = (r_timeout && (|w_others)) ? w_others : req;
  end
`else
  always_comb begin
    w_cand = req;
  end
`endif

  // Winner = minimum key: index itself in fixed mode, distance past last in rr.
  always_comb begin
    w_win      = '0;
    w_key      = 0;
    w_best_key = N;
    for (int i = 0; i < N; i++) begin
      w_key = mode ? ((i + N - 1 - int'(r_last)) % N) : i;
      if (w_cand[i] && (w_key < w_best_key)) begin
        w_best_key = w_key;
        w_win      = IDXW'(i);
      end
    end
    w_win_oh = {{(N-1){1'b0}}, 1'b1} << w_win;
  end

  assign w_owner_req = |(req & r_gnt);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
`ifdef HOLD_LIMIT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      IDLE: begin
`ifdef HOLD_LIMIT_EN
        w_timeout_nxt = 1'b0;
`endif
        if (|req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_win_oh;
          w_idx_nxt   = w_win;
          w_last_nxt  = w_win;
`ifdef HOLD_LIMIT_EN
          w_cnt_nxt   = CNTW'(1);
`endif
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
`ifdef HOLD_LIMIT_EN
        else if (r_cnt == CNTW'(MAX_HOLD)) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= IDXW'(N - 1);
`ifdef HOLD_LIMIT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
`ifdef HOLD_LIMIT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_req_grant_arbiter_n.sv
`default_nettype none
// Bench for req_grant_arbiter_n (N=4, MAX_HOLD=4): ownership model compared every
// cycle, plus directed vectors with literal expectations.
module tb_req_grant_arbiter_n;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDXW     = 2;

  logic            clk    = 1'b0;
  logic            resetn = 1'b0;
  logic            mode   = 1'b0;
  logic [N-1:0]    req    = '0;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;

  req_grant_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit en      = 1'b0;

  int m_owner   = -1;
  int m_last    = N - 1;
  int m_held    = 0;
  bit m_timeout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] r, input bit md, input int last, input bit to);
    logic [N-1:0] cand;
    logic [N-1:0] others;
    cand   = r;
    others = r & ~(4'b0001 << last);
    if (to && others != 0) cand = others;
    if (!md) begin
      for (int i = 0; i < N; i++) if (cand[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (cand[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Who owns the resource after each edge, from the arbitration rules.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_timeout = 1'b0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = pick(req, mode, m_last, m_timeout);
        m_last  = m_owner;
        m_held  = 1;
      end
      m_timeout = 1'b0;
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end
`ifdef HOLD_LIMIT_EN
    else if (m_held == MAX_HOLD) begin
      m_owner = -1; m_timeout = 1'b1;
    end
`endif
    else begin
      m_held++;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      check("model_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("model_valid", 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
      check("model_idx", 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    end
  end

  logic [N-1:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef HOLD_LIMIT_EN
  logic [N-1:0] hold_seq [15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
  logic [N-1:0] solo_seq [9]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0100};
`else
  logic [N-1:0] hold_seq [15] = '{default: 4'b0001};
  logic [N-1:0] solo_seq [9]  = '{default: 4'b0100};
`endif

  initial begin
    repeat (2) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_valid", 32'(gnt_valid), 32'd0);
    check("reset_idx", 32'(gnt_idx), 32'd0);
    resetn = 1'b1;
    en     = 1'b1;

    repeat (10) @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);

    mode = 1'b1; req = 4'b1000;
    @(negedge clk);
    check("rr_solo_gnt", 32'(gnt), 32'b1000);
    check("rr_solo_idx", 32'(gnt_idx), 32'd3);
    check("rr_solo_valid", 32'(gnt_valid), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("release_bubble", 32'(gnt), 32'd0);
    @(negedge clk);

    mode = 1'b0; req = 4'b0110;
    @(negedge clk);
    check("fixed_gnt", 32'(gnt), 32'b0010);
    check("fixed_idx", 32'(gnt_idx), 32'd1);
    req = 4'b0111;
    repeat (2) @(negedge clk);
    check("fixed_hold", 32'(gnt), 32'b0010);
    req = 4'b0101;
    @(negedge clk);
    check("fixed_bubble", 32'(gnt), 32'd0);
    @(negedge clk);
    check("fixed_next", 32'(gnt), 32'b0001);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    req = 4'b0100;
    @(negedge clk);
    check("pre_reset_gnt", 32'(gnt), 32'b0100);
    #2 resetn = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(gnt_valid), 32'd0);
    check("async_idx", 32'(gnt_idx), 32'd0);
    mode = 1'b1; req = 4'b1111;
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(gnt), 32'(rr_order[k]));
      @(negedge clk);
      check("rr_hold", 32'(gnt), 32'(rr_order[k]));
      req = 4'b1111 & ~rr_order[k];
      @(negedge clk);
      check("rr_bubble", 32'(gnt), 32'd0);
      req = 4'b1111;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    mode = 1'b0; req = 4'b0011;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("hold_seq", 32'(gnt), 32'(hold_seq[k]));
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    mode = 1'b1; req = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("solo_seq", 32'(gnt), 32'(solo_seq[k]));
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
